// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman drawing pipeline.
package hangman_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } plot_state_t;

  // True when the pixel lies inside a w x h screen.
  function automatic logic on_screen(input pixel_t p, input int unsigned w,
                                     input int unsigned h);
    return (32'(p.x) < w) && (32'(p.y) < h);
  endfunction

endpackage

// File: rtl/pixel_plot_sink_if.sv
// Plot-request stream from a drawing engine to the pixel sink.
interface pixel_plot_sink_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_color;

  modport master (output in_valid, in_x, in_y, in_color, input in_ready);
  modport slave  (input in_valid, in_x, in_y, in_color, output in_ready);
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of plot requests; head entry is visible on dout.
module pixel_fifo
  import hangman_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  pixel_t                   din,
  output pixel_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pixel_plot_sink.sv
// Buffers plot requests, clips them to the screen, drives the VGA write
// port at one pixel per cycle and runs the full-screen clear sweep.
module pixel_plot_sink
  import hangman_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XMAX  = SCREEN_W,
  parameter int unsigned YMAX  = SCREEN_H
) (
  input  logic                clk,
  input  logic                resetn,
  pixel_plot_sink_if.slave    req,
  input  logic                clr_req,
  input  logic [2:0]          clr_color,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [2:0]          vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                idle,
  output logic                clip_err,
  output logic [7:0]          drop_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [7:0] X_LAST = 8'(XMAX - 1);
  localparam logic [6:0] Y_LAST = 7'(YMAX - 1);

  plot_state_t    state;
  logic [7:0]     sx;
  logic [6:0]     sy;
  pixel_t         head;
  pixel_t         req_pix;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  // A pending clear with nothing queued blocks new requests so it can start.
  assign req.in_ready = !fifo_full && (state != ST_CLEAR) && !(clr_req && fifo_empty);
  assign idle         = (state == ST_IDLE) && fifo_empty && !clr_req;
  assign push         = req.in_valid && req.in_ready;
  assign pop          = (state != ST_CLEAR) && !fifo_empty;
  assign req_pix      = {req.in_x, req.in_y, req.in_color};

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (req_pix),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Plot FSM: drain the queue (popping straight out of IDLE) or sweep a clear.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state      <= ST_IDLE;
      sx         <= '0;
      sy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
      clip_err   <= 1'b0;
      drop_count <= '0;
    end else begin
      vga_plot <= 1'b0;
      clip_err <= 1'b0;
      case (state)
        ST_IDLE, ST_DRAIN: begin
          if (fifo_empty) begin
            if (clr_req) begin
              state      <= ST_CLEAR;
              sx         <= '0;
              sy         <= '0;
              vga_x      <= '0;
              vga_y      <= '0;
              vga_colour <= clr_color;
              vga_plot   <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            vga_x      <= head.x;
            vga_y      <= head.y;
            vga_colour <= head.c;
            if (on_screen(head, XMAX, YMAX)) begin
              vga_plot <= 1'b1;
            end else begin
              clip_err <= 1'b1;
              if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
            state <= (fifo_count == CW'(1) && !push) ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_CLEAR: begin
          if (sx == X_LAST && sy == Y_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            sx    <= '0;
            sy    <= '0;
          end else begin
            vga_plot <= 1'b1;
            if (sx == X_LAST) begin
              sx    <= '0;
              sy    <= sy + 7'd1;
              vga_x <= '0;
              vga_y <= sy + 7'd1;
            end else begin
              sx    <= sx + 8'd1;
              vga_x <= sx + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Self-checking bench for pixel_plot_sink: scoreboard of expected plots.
module tb_pixel_plot_sink;
  import hangman_pkg::*;

  logic       clk;
  logic       resetn;
  logic       clr_req;
  logic [2:0] clr_color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       idle;
  logic       clip_err;
  logic [7:0] drop_count;

  pixel_plot_sink_if bus ();

  pixel_plot_sink #(.DEPTH(8), .XMAX(160), .YMAX(120)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (bus),
    .clr_req    (clr_req),
    .clr_color  (clr_color),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .idle       (idle),
    .clip_err   (clip_err),
    .drop_count (drop_count)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       plot;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one request from the next falling edge until accepted; queue its expectation.
  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                      output int stalls);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_color = c;
    stalls       = 0;
    #1;
    while (!bus.in_ready && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (!bus.in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", bus.in_ready);
    end else begin
      e.x    = x;
      e.y    = y;
      e.c    = c;
      e.plot = (x < 8'd160) && (y < 7'd120);
      e.due  = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    resetn       = 1'b1;
    clr_req      = 1'b0;
    clr_color    = 3'd0;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_color = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vga_x, vga_y, vga_colour, vga_plot, busy, clip_err, drop_count} !== 30'd0)
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b clip=%b drop=%0d, required all 0",
               vga_x, vga_y, vga_colour, vga_plot, busy, clip_err, drop_count);
    else passed++;
    checks++;
    if ({bus.in_ready, idle} !== 2'b11)
      $display("FAIL reset_ready_idle: got in_ready=%b idle=%b, required 1 1", bus.in_ready, idle);
    else passed++;
    resetn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int   st;
    int   nout = 0;
    exp_t e;
    fork
      begin
        send(8'd10, 7'd20, COL_WHITE, st);
        @(negedge clk) bus.in_valid = 1'b0;
      end
      repeat (8) begin
        @(negedge clk);
        if (vga_plot || clip_err) begin
          nout++;
          checks++;
          if (sb.size() == 0)
            $display("FAIL single_extra: unexpected output x=%0d y=%0d", vga_x, vga_y);
          else begin
            e = sb.pop_front();
            if ({vga_x, vga_y, vga_colour, vga_plot, clip_err} !== {e.x, e.y, e.c, e.plot, ~e.plot} || cyc != e.due)
              $display("FAIL single_pixel: got x=%0d y=%0d c=%0d plot=%b clip=%b cyc=%0d, required x=%0d y=%0d c=%0d plot=%b cyc=%0d",
                       vga_x, vga_y, vga_colour, vga_plot, clip_err, cyc, e.x, e.y, e.c, e.plot, e.due);
            else passed++;
          end
        end
      end
    join
    checks++;
    if (nout != 1 || sb.size() != 0)
      $display("FAIL single_count: got %0d outputs (%0d pending), required 1 (0)", nout, sb.size());
    else passed++;
    checks++;
    if (idle !== 1'b1) $display("FAIL single_idle: got idle=%b, required 1", idle);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int   st;
    int   stalls = 0;
    int   nout = 0;
    int   first = -1;
    int   last = -1;
    exp_t e;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send(8'(i * 13), 7'(i * 9 + 1), 3'(i), st);
          stalls += st;
        end
        @(negedge clk) bus.in_valid = 1'b0;
      end
      repeat (20) begin
        @(negedge clk);
        if (vga_plot || clip_err) begin
          nout++;
          if (first < 0) first = cyc;
          last = cyc;
          checks++;
          if (sb.size() == 0)
            $display("FAIL b2b_extra: unexpected output x=%0d y=%0d", vga_x, vga_y);
          else begin
            e = sb.pop_front();
            if ({vga_x, vga_y, vga_colour, vga_plot, clip_err} !== {e.x, e.y, e.c, e.plot, ~e.plot} || cyc != e.due)
              $display("FAIL b2b_pixel: got x=%0d y=%0d c=%0d plot=%b clip=%b cyc=%0d, required x=%0d y=%0d c=%0d plot=%b cyc=%0d",
                       vga_x, vga_y, vga_colour, vga_plot, clip_err, cyc, e.x, e.y, e.c, e.plot, e.due);
            else passed++;
          end
        end
      end
    join
    checks++;
    if (stalls != 0) $display("FAIL b2b_ready: got %0d stall cycles, required 0", stalls);
    else passed++;
    checks++;
    if (nout != 12 || last - first != 11)
      $display("FAIL b2b_throughput: got %0d plots over %0d cycles, required 12 over 12", nout, last - first + 1);
    else passed++;
  endtask

  task automatic test_clip();
    int   st;
    exp_t e;
    fork
      begin
        send(8'd159, 7'd119, COL_RED, st);
        send(8'd160, 7'd5, COL_GREEN, st);
        @(negedge clk) bus.in_valid = 1'b0;
      end
      repeat (8) begin
        @(negedge clk);
        if (vga_plot || clip_err) begin
          checks++;
          if (sb.size() == 0)
            $display("FAIL clip_extra: unexpected output x=%0d y=%0d", vga_x, vga_y);
          else begin
            e = sb.pop_front();
            if ({vga_x, vga_y, vga_colour, vga_plot, clip_err} !== {e.x, e.y, e.c, e.plot, ~e.plot} || cyc != e.due)
              $display("FAIL clip_pixel: got x=%0d y=%0d c=%0d plot=%b clip=%b cyc=%0d, required x=%0d y=%0d c=%0d plot=%b cyc=%0d",
                       vga_x, vga_y, vga_colour, vga_plot, clip_err, cyc, e.x, e.y, e.c, e.plot, e.due);
            else passed++;
          end
        end
      end
    join
    checks++;
    if (drop_count !== 8'd1 || sb.size() != 0)
      $display("FAIL clip_one: got drop_count=%0d pending=%0d, required 1 0", drop_count, sb.size());
    else passed++;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if (i % 2 == 0) send(8'(160 + i % 96), 7'(i % 120), 3'(i), st);
          else            send(8'(i % 160), 7'(120 + i % 8), 3'(i), st);
        end
        @(negedge clk) bus.in_valid = 1'b0;
      end
      repeat (312) begin
        @(negedge clk);
        if (vga_plot || clip_err) begin
          checks++;
          if (sb.size() == 0)
            $display("FAIL sat_extra: unexpected output x=%0d y=%0d", vga_x, vga_y);
          else begin
            e = sb.pop_front();
            if ({vga_x, vga_y, vga_colour, vga_plot, clip_err} !== {e.x, e.y, e.c, e.plot, ~e.plot} || cyc != e.due)
              $display("FAIL sat_pixel: got x=%0d y=%0d c=%0d plot=%b clip=%b cyc=%0d, required x=%0d y=%0d c=%0d plot=%b cyc=%0d",
                       vga_x, vga_y, vga_colour, vga_plot, clip_err, cyc, e.x, e.y, e.c, e.plot, e.due);
            else passed++;
          end
        end
      end
    join
    checks++;
    if (drop_count !== 8'd255 || sb.size() != 0)
      $display("FAIL clip_saturate: got drop_count=%0d pending=%0d, required 255 0", drop_count, sb.size());
    else passed++;
  endtask

  task automatic test_clear_order();
    int         st;
    int         k = 0;
    int         nbusy = 0;
    int         bad = 0;
    int         rdy_bad = 0;
    int         first_busy = -1;
    int         last_plot = -1;
    logic       done = 1'b0;
    logic [7:0] ex = 8'd0;
    logic [6:0] ey = 7'd0;
    logic [7:0] lx = 8'd0;
    logic [6:0] ly = 7'd0;
    logic [2:0] lc = 3'd7;
    exp_t       e;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'(20 + i), 7'(30 + i), COL_BLUE, st);
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr_req      = 1'b1;
        clr_color    = COL_BLACK;
      end
      while (!done && k < 19400) begin
        @(negedge clk);
        k++;
        if (busy) begin
          nbusy++;
          if (first_busy < 0) first_busy = cyc;
          if (!vga_plot || clip_err || vga_x !== ex || vga_y !== ey || vga_colour !== COL_BLACK) bad++;
          if (bus.in_ready) rdy_bad++;
          lx = vga_x; ly = vga_y; lc = vga_colour;
          if (ex == 8'd159) begin ex = 8'd0; ey = ey + 7'd1; end
          else ex = ex + 8'd1;
        end else if (vga_plot || clip_err) begin
          last_plot = cyc;
          checks++;
          if (sb.size() == 0)
            $display("FAIL clr_extra: unexpected output x=%0d y=%0d", vga_x, vga_y);
          else begin
            e = sb.pop_front();
            if ({vga_x, vga_y, vga_colour, vga_plot, clip_err} !== {e.x, e.y, e.c, e.plot, ~e.plot} || cyc != e.due)
              $display("FAIL clr_queued: got x=%0d y=%0d c=%0d plot=%b cyc=%0d, required x=%0d y=%0d c=%0d plot=%b cyc=%0d",
                       vga_x, vga_y, vga_colour, vga_plot, cyc, e.x, e.y, e.c, e.plot, e.due);
            else passed++;
          end
        end else if (nbusy > 0) begin
          clr_req = 1'b0;
          done    = 1'b1;
        end
      end
    join
    checks++;
    if (!done) $display("FAIL clr_timeout: busy=%b after %0d cycles, required clear to finish", busy, k);
    else passed++;
    checks++;
    if (nbusy != 19200) $display("FAIL clr_length: got %0d busy cycles, required 19200", nbusy);
    else passed++;
    checks++;
    if (bad != 0 || rdy_bad != 0)
      $display("FAIL clr_sweep: got %0d bad pixels and %0d ready cycles, required 0 0", bad, rdy_bad);
    else passed++;
    checks++;
    if (first_busy != last_plot + 1 || sb.size() != 0)
      $display("FAIL clr_start: got busy at %0d after last plot %0d (pending %0d), required next cycle", first_busy, last_plot, sb.size());
    else passed++;
    checks++;
    if ({lx, ly, lc} !== {8'd159, 7'd119, 3'd0})
      $display("FAIL clr_last: got (%0d,%0d,%0d), required (159,119,0)", lx, ly, lc);
    else passed++;
    k = 0;
    repeat (3) begin @(negedge clk); if (vga_plot || busy) k++; end
    checks++;
    if (k != 0 || idle !== 1'b1)
      $display("FAIL clr_no_repeat: got %0d active cycles idle=%b, required 0 1", k, idle);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    int   k = 0;
    int   rdy_bad = 0;
    int   nbusy = 0;
    logic hit = 1'b0;
    @(negedge clk);
    clr_req      = 1'b1;
    clr_color    = COL_WHITE;
    bus.in_valid = 1'b1;
    bus.in_x     = 8'd5;
    bus.in_y     = 7'd5;
    bus.in_color = COL_RED;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL clr_wins: got in_ready=%b, required 0", bus.in_ready);
    else passed++;
    while (!hit && k < 20000) begin
      @(negedge clk);
      k++;
      if (bus.in_ready) rdy_bad++;
      if (busy && vga_x == 8'd40 && vga_y == 7'd60) hit = 1'b1;
    end
    checks++;
    if (!hit || rdy_bad != 0)
      $display("FAIL rst_reach: hit=%b ready cycles=%0d, required 1 0", hit, rdy_bad);
    else passed++;
    resetn       = 1'b1;
    clr_req      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if ({vga_x, vga_y, vga_colour, vga_plot, busy, clip_err, drop_count, bus.in_ready, idle} !== {30'd0, 2'b11})
      $display("FAIL rst_async: got x=%0d y=%0d c=%0d plot=%b busy=%b clip=%b drop=%0d rdy=%b idle=%b, required 0s with rdy=1 idle=1",
               vga_x, vga_y, vga_colour, vga_plot, busy, clip_err, drop_count, bus.in_ready, idle);
    else passed++;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({idle, bus.in_ready, vga_plot, busy} !== 4'b1100)
      $display("FAIL rst_release: got idle=%b rdy=%b plot=%b busy=%b, required 1 1 0 0", idle, bus.in_ready, vga_plot, busy);
    else passed++;
    clr_req   = 1'b1;
    clr_color = COL_GREEN;
    @(negedge clk);
    checks++;
    if ({busy, vga_plot, vga_x, vga_y, vga_colour} !== {2'b11, 8'd0, 7'd0, COL_GREEN})
      $display("FAIL rst_sweep_zero: got busy=%b plot=%b (%0d,%0d,%0d), required 1 1 (0,0,2)", busy, vga_plot, vga_x, vga_y, vga_colour);
    else passed++;
    clr_req = 1'b0;
    k = 0;
    while (busy && k < 19300) begin nbusy++; @(negedge clk); k++; end
    checks++;
    if (nbusy != 19200) $display("FAIL rst_clear_length: got %0d busy cycles, required 19200", nbusy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_clip();
    test_clear_order();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
